zap_ben_ram_ctrl: RTL and testbench

//  Sequencer/arbiter in front of a 128-bit x DEPTH byte-enable block RAM (1-cycle registered read).

---
 rtl/zap_ben_ram_ctrl_pkg.sv | 19 +
 rtl/zap_ben_ram_ctrl_fill_assembler.sv | 42 ++++
 rtl/zap_ben_ram_ctrl.sv | 152 +++++++++++++++
 tb/tb_zap_ben_ram_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/zap_ben_ram_ctrl_pkg.sv
// Shared types and constants for the byte-enable RAM controller.
// Fill sequencing states, line geometry and the store byte-lane helper.
package zap_ben_ram_ctrl_pkg;

  localparam int LINE_W     = 128;
  localparam int FILL_BEATS = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_COMMIT = 2'd2
  } fill_state_e;

  // Byte enables of a 32-bit word placed in its lane of the 128-bit line.
  function automatic logic [15:0] word_ben(input logic [1:0] word, input logic [3:0] ben);
    return {12'b0, ben} << {word, 2'b00};
  endfunction

endpackage

// File: rtl/zap_ben_ram_ctrl_fill_assembler.sv
// Collects four 32-bit fill beats (word 0 first) into one 128-bit line.
// o_last_beat flags the beat that completes the line.
module zap_fill_assembler
  import zap_ben_ram_ctrl_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_clear,
  input  logic              i_beat_valid,
  input  logic [31:0]       i_beat_data,
  output logic [LINE_W-1:0] o_line,
  output logic              o_last_beat
);

  logic [1:0]        cnt_q, cnt_d;
  logic [LINE_W-1:0] buf_q, buf_d;

  always_comb begin
    cnt_d = cnt_q;
    buf_d = buf_q;
    if (i_clear) begin
      cnt_d = 2'd0;
    end else if (i_beat_valid) begin
      buf_d[32*cnt_q +: 32] = i_beat_data;
      cnt_d                 = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_q <= 2'd0;
      buf_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      buf_q <= buf_d;
    end
  end

  assign o_line      = buf_q;
  assign o_last_beat = i_beat_valid && (cnt_q == 2'(FILL_BEATS - 1));

endmodule

// File: rtl/zap_ben_ram_ctrl.sv
// Arbiter/sequencer for a 128-bit byte-enable block RAM shared by a CPU store
// port, a four-beat line-fill engine and a line read port.
// Handshake: a request is held high until its combinational ack; the transfer
// happens in the cycle where req and ack are both high.
module zap_ben_ram_ctrl
  import zap_ben_ram_ctrl_pkg::*;
#(
  parameter  int DEPTH = 32,
  localparam int LW    = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_st_req,
  input  logic [LW+1:0]     i_st_addr,
  input  logic [3:0]        i_st_ben,
  input  logic [31:0]       i_st_data,
  output logic              o_st_ack,
  input  logic              i_fill_start,
  input  logic [LW-1:0]     i_fill_line,
  input  logic              i_fill_valid,
  input  logic [31:0]       i_fill_data,
  output logic              o_fill_busy,
  output logic              o_fill_done,
  input  logic              i_rd_req,
  input  logic [LW-1:0]     i_rd_line,
  output logic              o_rd_ack,
  output logic              o_rd_valid,
  output logic [LINE_W-1:0] o_rd_data,
  output logic [15:0]       o_ram_ben,
  output logic [LW-1:0]     o_ram_waddr,
  output logic [LINE_W-1:0] o_ram_wdata,
  output logic              o_ram_ren,
  output logic [LW-1:0]     o_ram_raddr,
  input  logic [LINE_W-1:0] i_ram_rdata,
  output logic [1:0]        o_dbg_state
);

  fill_state_e       state_q, state_d;
  logic [LW-1:0]     fill_line_q, fill_line_d;
  logic              fill_clear, beat_valid, last_beat;
  logic [LINE_W-1:0] fill_buf;

  logic [15:0]       ben_q, ben_d;
  logic [LW-1:0]     waddr_q, waddr_d, raddr_q, raddr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic              ren_q, ren_d, rd_valid_q, busy_q, busy_d, done_q;

  logic [LW-1:0]     st_line;
  logic [1:0]        st_word;
  logic              st_ack, rd_ack, wr_hit;

  assign st_line = i_st_addr[LW+1:2];
  assign st_word = i_st_addr[1:0];

  zap_fill_assembler u_fill (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_clear      (fill_clear),
    .i_beat_valid (beat_valid),
    .i_beat_data  (i_fill_data),
    .o_line       (fill_buf),
    .o_last_beat  (last_beat)
  );

  always_comb begin
    state_d     = state_q;
    fill_line_d = fill_line_q;
    fill_clear  = 1'b0;
    beat_valid  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_fill_start) begin
          state_d     = ST_FILL;
          fill_line_d = i_fill_line;
          fill_clear  = 1'b1;
        end
      end
      ST_FILL: begin
        beat_valid = i_fill_valid;
        if (last_beat) state_d = ST_COMMIT;
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // COMMIT owns the write port; during FILL a store to the fill line waits so
  // that its bytes land on top of the completed line rather than under it.
  always_comb begin
    st_ack = i_st_req && (state_q != ST_COMMIT) &&
             !((state_q == ST_FILL) && (st_line == fill_line_q));
    wr_hit = ((state_q == ST_COMMIT) && (fill_line_q == i_rd_line)) ||
             (st_ack && (i_st_ben != 4'd0) && (st_line == i_rd_line));
    rd_ack = i_rd_req && !wr_hit;

    ben_d   = 16'd0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (state_q == ST_COMMIT) begin
      ben_d   = 16'hFFFF;
      waddr_d = fill_line_q;
      wdata_d = fill_buf;
    end else if (st_ack) begin
      ben_d   = word_ben(st_word, i_st_ben);
      waddr_d = st_line;
      wdata_d = {4{i_st_data}};
    end
    ren_d   = rd_ack;
    raddr_d = rd_ack ? i_rd_line : raddr_q;
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= ST_IDLE;
      fill_line_q <= '0;
      ben_q       <= '0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      ren_q       <= 1'b0;
      raddr_q     <= '0;
      rd_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_line_q <= fill_line_d;
      ben_q       <= ben_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      ren_q       <= ren_d;
      raddr_q     <= raddr_d;
      rd_valid_q  <= ren_q;
      busy_q      <= busy_d;
      done_q      <= (state_q == ST_COMMIT);
    end
  end

  assign o_st_ack    = st_ack;
  assign o_rd_ack    = rd_ack;
  assign o_fill_busy = busy_q;
  assign o_fill_done = done_q;
  assign o_rd_valid  = rd_valid_q;
  assign o_rd_data   = i_ram_rdata;
  assign o_ram_ben   = ben_q;
  assign o_ram_waddr = waddr_q;
  assign o_ram_wdata = wdata_q;
  assign o_ram_ren   = ren_q;
  assign o_ram_raddr = raddr_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_zap_ben_ram_ctrl.sv
// Bench for zap_ben_ram_ctrl: behavioural RAM, line-level memory model and
// directed plus randomized traffic on the store, fill and read ports.
module tb_zap_ben_ram_ctrl;

  logic         i_clk = 1'b0;
  logic         i_reset_n;
  logic         i_st_req;
  logic [6:0]   i_st_addr;
  logic [3:0]   i_st_ben;
  logic [31:0]  i_st_data;
  logic         o_st_ack;
  logic         i_fill_start;
  logic [4:0]   i_fill_line;
  logic         i_fill_valid;
  logic [31:0]  i_fill_data;
  logic         o_fill_busy;
  logic         o_fill_done;
  logic         i_rd_req;
  logic [4:0]   i_rd_line;
  logic         o_rd_ack;
  logic         o_rd_valid;
  logic [127:0] o_rd_data;
  logic [15:0]  o_ram_ben;
  logic [4:0]   o_ram_waddr;
  logic [127:0] o_ram_wdata;
  logic         o_ram_ren;
  logic [4:0]   o_ram_raddr;
  logic [127:0] i_ram_rdata;
  logic [1:0]   o_dbg_state;

  zap_ben_ram_ctrl #(.DEPTH(32)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_st_req(i_st_req), .i_st_addr(i_st_addr), .i_st_ben(i_st_ben),
    .i_st_data(i_st_data), .o_st_ack(o_st_ack),
    .i_fill_start(i_fill_start), .i_fill_line(i_fill_line),
    .i_fill_valid(i_fill_valid), .i_fill_data(i_fill_data),
    .o_fill_busy(o_fill_busy), .o_fill_done(o_fill_done),
    .i_rd_req(i_rd_req), .i_rd_line(i_rd_line), .o_rd_ack(o_rd_ack),
    .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data),
    .o_ram_ben(o_ram_ben), .o_ram_waddr(o_ram_waddr), .o_ram_wdata(o_ram_wdata),
    .o_ram_ren(o_ram_ren), .o_ram_raddr(o_ram_raddr), .i_ram_rdata(i_ram_rdata),
    .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;

  // behavioural block RAM: byte-enable write, registered read
  logic [127:0] ram [32];
  always @(posedge i_clk) begin
    for (int b = 0; b < 16; b++)
      if (o_ram_ben[b]) ram[o_ram_waddr][8*b +: 8] <= o_ram_wdata[8*b +: 8];
    if (o_ram_ren) i_ram_rdata <= ram[o_ram_raddr];
  end

  // reference model: expected RAM contents and fill progress
  logic [127:0] exp_mem [32];
  logic [128:0] exp_q[$];   // {valid, data} expected on the read return, per cycle
  int           m_phase;    // 0 idle, 1 collecting beats, 2 line write cycle
  int           m_cnt;
  logic [4:0]   m_line;
  logic [31:0]  m_beats [4];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_cnt   = 0;
    exp_q.delete();
    exp_q.push_back(129'd0);
    exp_q.push_back(129'd0);
  endtask

  // asynchronous reset applied at a negedge, released a cycle later
  task automatic do_reset();
    i_reset_n = 1'b0;
    #1;
    chk("rst_ben", o_ram_ben, 16'd0);
    chk("rst_ren", o_ram_ren, 1'b0);
    chk("rst_busy", o_fill_busy, 1'b0);
    chk("rst_done", o_fill_done, 1'b0);
    chk("rst_rd_valid", o_rd_valid, 1'b0);
    @(posedge i_clk);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    model_reset();
  endtask

  // one clock cycle of stimulus; returns the acks the model predicts
  task automatic cycle(input logic sreq, input logic [6:0] saddr, input logic [3:0] sben,
                       input logic [31:0] sdat, input logic fst, input logic [4:0] fln,
                       input logic fv, input logic [31:0] fd, input logic rreq,
                       input logic [4:0] rln, output logic s_ok, output logic r_ok);
    logic [4:0]   sline;
    int           sw;
    logic         wr_v, e_done;
    logic [4:0]   wr_l;
    logic [15:0]  e_ben;
    logic [4:0]   e_waddr;
    logic [127:0] e_wdata;
    logic [128:0] pv;
    i_st_req = sreq; i_st_addr = saddr; i_st_ben = sben; i_st_data = sdat;
    i_fill_start = fst; i_fill_line = fln; i_fill_valid = fv; i_fill_data = fd;
    i_rd_req = rreq; i_rd_line = rln;
    #1;
    sline = saddr[6:2];
    sw    = int'(saddr[1:0]);
    s_ok  = sreq && (m_phase != 2) && !(m_phase == 1 && sline == m_line);
    wr_v = 1'b0; wr_l = '0; e_ben = '0; e_waddr = '0; e_wdata = '0;
    if (m_phase == 2) begin
      wr_v    = 1'b1;
      wr_l    = m_line;
      e_ben   = 16'hFFFF;
      e_waddr = m_line;
      e_wdata = {m_beats[3], m_beats[2], m_beats[1], m_beats[0]};
      exp_mem[m_line] = e_wdata;
    end else if (s_ok) begin
      for (int b = 0; b < 4; b++)
        if (sben[b]) begin
          e_ben[4*sw + b] = 1'b1;
          exp_mem[sline][32*sw + 8*b +: 8] = sdat[8*b +: 8];
        end
      e_waddr = sline;
      e_wdata = {4{sdat}};
      wr_v    = (sben != 4'd0);
      wr_l    = sline;
    end
    r_ok = rreq && !(wr_v && wr_l == rln);
    chk("st_ack", o_st_ack, s_ok);
    chk("rd_ack", o_rd_ack, r_ok);
    pv = exp_q.pop_front();
    chk("rd_valid", o_rd_valid, pv[128]);
    if (pv[128]) chk("rd_data", o_rd_data, pv[127:0]);
    exp_q.push_back(r_ok ? {1'b1, exp_mem[rln]} : 129'd0);

    e_done = (m_phase == 2);
    case (m_phase)
      0: if (fst) begin m_phase = 1; m_cnt = 0; m_line = fln; end
      1: if (fv) begin
           m_beats[m_cnt] = fd;
           m_cnt++;
           if (m_cnt == 4) m_phase = 2;
         end
      default: m_phase = 0;
    endcase

    @(posedge i_clk);
    #1;
    chk("ram_ben", o_ram_ben, e_ben);
    if (e_ben != 16'd0) begin
      chk("ram_waddr", o_ram_waddr, e_waddr);
      chk("ram_wdata", o_ram_wdata, e_wdata);
    end
    chk("ram_ren", o_ram_ren, r_ok);
    if (r_ok) chk("ram_raddr", o_ram_raddr, rln);
    chk("fill_busy", o_fill_busy, m_phase != 0);
    chk("fill_done", o_fill_done, e_done);
    @(negedge i_clk);
  endtask

  task automatic idle(input int n);
    logic a, b;
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, a, b);
  endtask

  initial begin
    logic         sa, ra;
    logic [31:0]  beats [4];
    logic         sp, rp, fs, fv;
    logic [6:0]   spa;
    logic [3:0]   spb;
    logic [31:0]  spd;
    logic [4:0]   rpl;
    logic [127:0] v;
    int           k;

    beats[0] = 32'h11111111; beats[1] = 32'h22222222;
    beats[2] = 32'h33333333; beats[3] = 32'h44444444;
    for (int i = 0; i < 32; i++) begin
      v = {$urandom, $urandom, $urandom, $urandom};
      ram[i]     <= v;
      exp_mem[i]  = v;
    end
    i_reset_n = 1'b1;
    i_st_req = 0; i_st_addr = 0; i_st_ben = 0; i_st_data = 0;
    i_fill_start = 0; i_fill_line = 0; i_fill_valid = 0; i_fill_data = 0;
    i_rd_req = 0; i_rd_line = 0;
    #2 i_reset_n = 1'b0;
    @(negedge i_clk);
    do_reset();
    idle(2);

    // reset in the middle of a fill of line 5 discards it
    cycle(0, 0, 0, 0, 1, 5'd5, 0, 0, 0, 0, sa, ra);
    cycle(0, 0, 0, 0, 0, 0, 1, 32'hDEAD0000, 0, 0, sa, ra);
    cycle(0, 0, 0, 0, 0, 0, 1, 32'hDEAD0001, 0, 0, sa, ra);
    do_reset();
    idle(2);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd5, sa, ra);
    idle(3);

    // full fill of line 5
    cycle(0, 0, 0, 0, 1, 5'd5, 0, 0, 0, 0, sa, ra);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 0, 1, beats[i], 0, 0, sa, ra);
    idle(3);

    // store to the fill line is held off until the fill has committed
    cycle(0, 0, 0, 0, 1, 5'd5, 0, 0, 0, 0, sa, ra);
    for (int i = 0; i < 4; i++)
      cycle(1, {5'd5, 2'd2}, 4'b0011, 32'hAABBCCDD, 0, 0, 1, beats[i], 0, 0, sa, ra);
    k = 0;
    do begin
      cycle(1, {5'd5, 2'd2}, 4'b0011, 32'hAABBCCDD, 0, 0, 0, 0, 0, 0, sa, ra);
      k++;
    end while (!sa && k < 8);
    chk("t3_ack_bound", sa, 1'b1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd5, sa, ra);
    idle(3);

    // store and read of line 3 in the same cycle: read retries
    cycle(1, {5'd3, 2'd1}, 4'hF, 32'h0BADF00D, 0, 0, 0, 0, 1, 5'd3, sa, ra);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd3, sa, ra);
    idle(3);

    // store to another line during FILL, and during COMMIT
    cycle(0, 0, 0, 0, 1, 5'd5, 0, 0, 0, 0, sa, ra);
    cycle(1, {5'd7, 2'd0}, 4'b1010, 32'h12345678, 0, 0, 1, 32'hA0A0A0A0, 0, 0, sa, ra);
    cycle(0, 0, 0, 0, 0, 0, 1, 32'hA1A1A1A1, 0, 0, sa, ra);
    cycle(0, 0, 0, 0, 0, 0, 1, 32'hA2A2A2A2, 0, 0, sa, ra);
    cycle(0, 0, 0, 0, 0, 0, 1, 32'hA3A3A3A3, 0, 0, sa, ra);
    cycle(1, {5'd7, 2'd3}, 4'b0110, 32'h87654321, 0, 0, 0, 0, 0, 0, sa, ra);
    cycle(1, {5'd7, 2'd3}, 4'b0110, 32'h87654321, 0, 0, 0, 0, 0, 0, sa, ra);
    idle(2);

    // sweep of reads over every line, with a fill and a stray fill start
    for (int i = 0; i < 32; i++) begin
      fs = (i == 0) || (i == 3);
      fv = (i >= 2 && i <= 5);
      cycle(0, 0, 0, 0, fs, (i == 0) ? 5'd12 : 5'd20, fv, $urandom, 1, 5'(i), sa, ra);
      k = 0;
      while (!ra && k < 4) begin
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'(i), sa, ra);
        k++;
      end
    end
    idle(3);

    // randomized traffic with held requests
    sp = 0; rp = 0; spa = 0; spb = 0; spd = 0; rpl = 0;
    for (int c = 0; c < 400; c++) begin
      if (!sp && $urandom_range(0, 1) == 1) begin
        sp = 1; spa = 7'($urandom); spb = 4'($urandom); spd = $urandom;
      end
      if (!rp && $urandom_range(0, 2) != 0) begin
        rp = 1; rpl = 5'($urandom);
      end
      cycle(sp, spa, spb, spd, $urandom_range(0, 7) == 0, 5'($urandom),
            $urandom_range(0, 1) == 1, $urandom, rp, rpl, sa, ra);
      if (sa) sp = 0;
      if (ra) rp = 0;
    end
    idle(12);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
